seven_seg_scan: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 16 +
 rtl/hex_to_seg7.sv | 11 +
 rtl/seven_seg_scan.sv | 110 +++++++++++
 tb/tb_seven_seg_scan.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 8-digit seven-segment scanner.
package seven_seg_pkg;

   localparam int unsigned N_DIGITS = 8;
   localparam int unsigned SEG_W    = 7;
   localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

   typedef enum logic {ON, BLANK} state_t;

   // Active-low {g,f,e,d,c,b,a} patterns; entry 0 is the rightmost element.
   localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
   import seven_seg_pkg::*;
(
   input  logic [3:0]       nibble,
   output logic [SEG_W-1:0] seg_c
);

   assign seg_c = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 8-digit seven-segment driver with inter-digit blanking.
// Optional macro SEG_BLANK_LEADING_ZEROS_EN suppresses leading zero digits.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int unsigned PRESCALE  = 50000,
   parameter int unsigned BLANK_CYC = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         value,
   input  logic [N_DIGITS-1:0] dp_mask,
   input  logic                load,
   output logic [N_DIGITS-1:0] an,
   output logic [SEG_W-1:0]    seg,
   output logic                dp,
   output logic                frame_done
);

   localparam int unsigned IDX_W = $clog2(N_DIGITS);
   localparam int unsigned CNT_W = 20;
   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

   state_t              state, state_d;
   logic [IDX_W-1:0]    idx, idx_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [31:0]         shadow_val, shadow_val_d;
   logic [N_DIGITS-1:0] shadow_dp, shadow_dp_d;
   logic                wrap_d;
   logic [31:0]         digit_shift_c;
   logic [SEG_W-1:0]    dec_seg_c;
   logic [SEG_W-1:0]    digit_seg_c;

   // Next-state logic; outputs are registered from these next values so they
   // are valid in the first cycle of every state.
   always_comb begin
      state_d      = state;
      idx_d        = idx;
      cnt_d        = cnt + CNT_W'(1);
      wrap_d       = 1'b0;
      shadow_val_d = load ? value   : shadow_val;
      shadow_dp_d  = load ? dp_mask : shadow_dp;
      case (state)
         ON: begin
            if (cnt == ON_LAST) begin
               state_d = BLANK;
               cnt_d   = '0;
            end
         end
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_d = ON;
               cnt_d   = '0;
               idx_d   = idx + IDX_W'(1);
               wrap_d  = (idx == IDX_LAST);
            end
         end
         default: begin
            state_d = ON;
            cnt_d   = '0;
         end
      endcase
   end

   assign digit_shift_c = shadow_val_d >> {idx_d, 2'b00};

   hex_to_seg7 u_dec (
      .nibble (4'(digit_shift_c)),
      .seg_c  (dec_seg_c)
   );

`ifdef SEG_BLANK_LEADING_ZEROS_EN
   assign digit_seg_c = ((idx_d != '0) && (digit_shift_c == '0)) ? SEG_OFF : dec_seg_c;
`else
   assign digit_seg_c = dec_seg_c;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ON;
         idx        <= '0;
         cnt        <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         frame_done <= 1'b0;
         an         <= ~N_DIGITS'(1);
         seg        <= SEG_TABLE[0];
         dp         <= 1'b1;
      end else begin
         state      <= state_d;
         idx        <= idx_d;
         cnt        <= cnt_d;
         shadow_val <= shadow_val_d;
         shadow_dp  <= shadow_dp_d;
         frame_done <= wrap_d;
         if (state_d == ON) begin
            an  <= ~(N_DIGITS'(1) << idx_d);
            seg <= digit_seg_c;
            dp  <= ~shadow_dp_d[idx_d];
         end else begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan with PRESCALE=4, BLANK_CYC=2.
module tb_seven_seg_scan;

   localparam int PRE    = 4;
   localparam int BLK    = 2;
   localparam int PERIOD = PRE + BLK;
   localparam int FRAME  = 8 * PERIOD;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] value = '0;
   logic [7:0]  dp_mask = '0;
   logic        load = 1'b0;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   seven_seg_scan #(.PRESCALE(PRE), .BLANK_CYC(BLK)) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .dp_mask    (dp_mask),
      .load       (load),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference state: cycles since reset release plus the loaded display word.
   int          t = 0;
   logic [31:0] sh_val = '0;
   logic [7:0]  sh_dp = '0;
   logic [6:0]  hex_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
      end
   endtask

   function automatic logic [6:0] model_seg(input int d);
      logic [31:0] upper;
      upper = sh_val >> (4 * d);
`ifdef SEG_BLANK_LEADING_ZEROS_EN
      if (d >= 1 && upper == 0) return 7'h7F;
`endif
      return hex_seg[upper[3:0]];
   endfunction

   task automatic check_model();
      int d, ph;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic e_dp, e_fd;
      d  = (t / PERIOD) % 8;
      ph = t % PERIOD;
      if (ph < PRE) begin
         e_an  = ~(8'd1 << d);
         e_seg = model_seg(d);
         e_dp  = ~sh_dp[d];
      end else begin
         e_an  = 8'hFF;
         e_seg = 7'h7F;
         e_dp  = 1'b1;
      end
      e_fd = (t > 0) && (t % FRAME == 0);
      chk("cycle_outputs", {15'd0, an, seg, dp, frame_done}, {15'd0, e_an, e_seg, e_dp, e_fd});
      chk("anode_onehot", ($countones(~an) <= 1), 1);
   endtask

   task automatic step(input logic r, input logic l, input logic [31:0] v, input logic [7:0] m);
      rst = r; load = l; value = v; dp_mask = m;
      @(posedge clk);
      if (r) begin
         t = 0; sh_val = '0; sh_dp = '0;
      end else begin
         t++;
         if (l) begin sh_val = v; sh_dp = m; end
      end
      #1;
      check_model();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, $urandom, 8'($urandom));
   endtask

   // Advance until t mod FRAME equals target; an unreachable target is a failure.
   task automatic run_to(input int target);
      bit hit = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         idle();
         if (t % FRAME == target) begin hit = 1; break; end
      end
      chk("run_to_reached", 32'(hit), 1);
   endtask

   typedef struct {
      logic [31:0] val;
      logic [7:0]  mask;
      int          digit;
      logic [6:0]  exp_seg;
      logic        exp_dp;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [7:0] e_seq [7] = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFD};
      int pulses;
      int last_pulse;

      vecs[0] = '{32'h12345678, 8'h01, 0, 7'h00, 1'b0};
      vecs[1] = '{32'h12345678, 8'h01, 7, 7'h79, 1'b1};
      vecs[2] = '{32'h0000ABCD, 8'h00, 3, 7'h08, 1'b1};
      vecs[3] = '{32'h0000ABCD, 8'h00, 0, 7'h21, 1'b1};
`ifdef SEG_BLANK_LEADING_ZEROS_EN
      vecs[4] = '{32'h0000ABCD, 8'h10, 4, 7'h7F, 1'b0};
      vecs[5] = '{32'h00000000, 8'h04, 2, 7'h7F, 1'b0};
`else
      vecs[4] = '{32'h0000ABCD, 8'h10, 4, 7'h40, 1'b0};
      vecs[5] = '{32'h00000000, 8'h04, 2, 7'h40, 1'b0};
`endif
      vecs[6] = '{32'h00000000, 8'h00, 0, 7'h40, 1'b1};
      vecs[7] = '{32'hFFFFFFFF, 8'h80, 7, 7'h0E, 1'b0};

      // Reset state and first digit/blank/next-digit sequence.
      step(1'b1, 1'b1, 32'hDEADBEEF, 8'hFF);
      chk("reset_seg", 32'(seg), 32'h40);
      chk("reset_dp", 32'(dp), 1);
      chk("reset_fd", 32'(frame_done), 0);
      chk("reset_an", 32'(an), 32'hFE);
      for (int i = 1; i < 7; i++) begin
         idle();
         chk("boot_an_seq", 32'(an), 32'(e_seq[i]));
      end

      // Table vectors: load after reset, then inspect the first ON cycle of a digit.
      foreach (vecs[k]) begin
         step(1'b1, 1'b0, 32'h0, 8'h0);
         step(1'b0, 1'b1, vecs[k].val, vecs[k].mask);
         run_to(vecs[k].digit * PERIOD);
         chk($sformatf("vec%0d_seg", k), 32'(seg), 32'(vecs[k].exp_seg));
         chk($sformatf("vec%0d_dp", k), 32'(dp), 32'(vecs[k].exp_dp));
      end

      // frame_done cadence over three frames.
      step(1'b1, 1'b0, 32'h0, 8'h0);
      step(1'b0, 1'b1, 32'h12345678, 8'h01);
      pulses = 0; last_pulse = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         idle();
         if (frame_done === 1'b1) begin
            if (pulses > 0) chk("fd_spacing", 32'(t - last_pulse), 32'(FRAME));
            pulses++;
            last_pulse = t;
         end
      end
      chk("fd_count", 32'(pulses), 3);

      // Mid-dwell load on digit 3 takes effect the next cycle without disturbing the scan.
      run_to(3 * PERIOD + 1);
      step(1'b0, 1'b1, 32'hFFFFFFFF, 8'h00);
      chk("midload_seg", 32'(seg), 32'h0E);
      chk("midload_an", 32'(an), 32'hF7);
      idle();
      chk("midload_an_hold", 32'(an), 32'hF7);
      idle();
      chk("midload_blank", 32'(an), 32'hFF);

      // Reset during the final BLANK of a frame suppresses the wrap pulse.
      run_to(7 * PERIOD + PRE);
      chk("pre_rst_blank", 32'(an), 32'hFF);
      step(1'b1, 1'b1, 32'h87654321, 8'hFF);
      chk("rst_blank_fd", 32'(frame_done), 0);
      chk("rst_blank_an", 32'(an), 32'hFE);
      chk("rst_blank_seg", 32'(seg), 32'h40);
      chk("rst_blank_dp", 32'(dp), 1);
      idle();
      chk("rst_blank_fd2", 32'(frame_done), 0);

      // Randomized loads against the reference model.
      for (int i = 0; i < 4 * FRAME; i++) begin
         if ($urandom_range(0, 15) == 0)
            step(1'b0, 1'b1, $urandom, 8'($urandom));
         else if ($urandom_range(0, 199) == 0)
            step(1'b1, 1'($urandom), $urandom, 8'($urandom));
         else
            idle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
